// File: rtl/ntt_ctrl.sv
// Stage/address sequencer for an in-place radix-2 DIF NTT driving one pipelined butterfly.
// Optional cycle counter output cyc_cnt is enabled with `define NTT_CTRL_CYCCNT_EN.
module ntt_ctrl #(
  parameter int N      = 256,
  parameter int LOGN   = 8,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [3:0]      stage,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr0,
  output logic [LOGN-1:0] rd_addr1,
  output logic [LOGN-2:0] tw_addr,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr0,
  output logic [LOGN-1:0] wr_addr1
`ifdef NTT_CTRL_CYCCNT_EN
  ,
  output logic [31:0]     cyc_cnt
`endif
);

  localparam int D   = RD_LAT + BF_LAT;
  localparam int JW  = LOGN - 1;
  localparam int DCW = (D > 1) ? $clog2(D) : 1;
  localparam int WBW = 2 * LOGN + 1;

  localparam logic [JW-1:0]  J_LAST = JW'(N / 2 - 1);
  localparam logic [3:0]     S_LAST = 4'(LOGN - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(D - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_n;
  logic [JW-1:0]  j_q, j_n;
  logic [3:0]     stage_q, stage_n;
  logic [DCW-1:0] dcnt_q, dcnt_n;

  logic            rd_en_n, busy_n, done_n;
  logic [LOGN-1:0] rd_addr0_n, rd_addr1_n;
  logic [LOGN-2:0] tw_addr_n;

  logic [LOGN-1:0] jx, hmask, k, a0;
  logic [3:0]      sh;

  // Write-back delay line: {vld, addr0, addr1}, D stages deep
  logic [WBW-1:0] wb_p [D];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      j_q      <= '0;
      stage_q  <= '0;
      dcnt_q   <= '0;
      rd_en    <= 1'b0;
      rd_addr0 <= '0;
      rd_addr1 <= '0;
      tw_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_n;
      j_q      <= j_n;
      stage_q  <= stage_n;
      dcnt_q   <= dcnt_n;
      rd_en    <= rd_en_n;
      rd_addr0 <= rd_addr0_n;
      rd_addr1 <= rd_addr1_n;
      tw_addr  <= tw_addr_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    j_n     = j_q;
    stage_n = stage_q;
    dcnt_n  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n = S_ISSUE;
          j_n     = '0;
          stage_n = '0;
        end
      end
      S_ISSUE: begin
        if (j_q == J_LAST) begin
          state_n = S_DRAIN;
          dcnt_n  = '0;
        end else begin
          j_n = j_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Wait until the last write of this stage has landed before rereading
        if (dcnt_q == D_LAST) begin
          if (stage_q == S_LAST) begin
            state_n = S_DONE;
            stage_n = '0;
          end else begin
            state_n = S_ISSUE;
            stage_n = stage_q + 4'd1;
            j_n     = '0;
          end
        end else begin
          dcnt_n = dcnt_q + 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register in step with it
  always_comb begin
    jx         = {1'b0, j_n};
    sh         = 4'(LOGN - 1) - stage_n;
    hmask      = {LOGN{1'b1}} >> (stage_n + 4'd1);
    k          = jx & hmask;
    a0         = ((jx >> sh) << (sh + 4'd1)) | k;
    rd_en_n    = (state_n == S_ISSUE);
    rd_addr0_n = '0;
    rd_addr1_n = '0;
    tw_addr_n  = '0;
    if (rd_en_n) begin
      rd_addr0_n = a0;
      rd_addr1_n = a0 + (hmask + 1'b1);
      tw_addr_n  = JW'(k << stage_n);
    end
    busy_n = (state_n == S_ISSUE) || (state_n == S_DRAIN);
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < D; i++) wb_p[i] <= '0;
    end else begin
      wb_p[0] <= {rd_en, rd_addr0, rd_addr1};
      for (int i = 1; i < D; i++) wb_p[i] <= wb_p[i-1];
    end
  end

  assign wr_en    = wb_p[D-1][WBW-1];
  assign wr_addr0 = wb_p[D-1][2*LOGN-1:LOGN];
  assign wr_addr1 = wb_p[D-1][LOGN-1:0];
  assign stage    = stage_q;

`ifdef NTT_CTRL_CYCCNT_EN
  // Loading 1 on start counts the first issue cycle, so a run totals LOGN*(N/2+D)+1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt <= '0;
    end else if (state_q == S_IDLE && start) begin
      cyc_cnt <= 32'd1;
    end else if (busy && cyc_cnt != '1) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_ctrl.sv
// Scoreboard bench for ntt_ctrl: N=8 directed runs (restart, ignored start, abort) and an N=256 run.
module tb_ntt_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start8 = 1'b0;
  logic start256 = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       busy8, done8, rd8, wr8;
  logic [3:0] stg8;
  logic [2:0] ra0_8, ra1_8, wa0_8, wa1_8;
  logic [1:0] tw8;
  logic       busy256, done256, rd256, wr256;
  logic [3:0] stg256;
  logic [7:0] ra0_256, ra1_256, wa0_256, wa1_256;
  logic [6:0] tw256;
`ifdef NTT_CTRL_CYCCNT_EN
  logic [31:0] cc8, cc256;
`endif

  ntt_ctrl #(.N(8), .LOGN(3), .RD_LAT(1), .BF_LAT(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .busy(busy8), .done(done8), .stage(stg8),
    .rd_en(rd8), .rd_addr0(ra0_8), .rd_addr1(ra1_8), .tw_addr(tw8),
    .wr_en(wr8), .wr_addr0(wa0_8), .wr_addr1(wa1_8)
`ifdef NTT_CTRL_CYCCNT_EN
    , .cyc_cnt(cc8)
`endif
  );

  ntt_ctrl #(.N(256), .LOGN(8), .RD_LAT(1), .BF_LAT(8)) u256 (
    .clk(clk), .reset(reset), .start(start256), .busy(busy256), .done(done256), .stage(stg256),
    .rd_en(rd256), .rd_addr0(ra0_256), .rd_addr1(ra1_256), .tw_addr(tw256),
    .wr_en(wr256), .wr_addr0(wa0_256), .wr_addr1(wa1_256)
`ifdef NTT_CTRL_CYCCNT_EN
    , .cyc_cnt(cc256)
`endif
  );

  typedef struct {int cyc; int stg; int a0; int a1; int tw;} ev_t;
  ev_t rq8[$], wq8[$], rq256[$], wq256[$];
  int  dq8[$], dq256[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Hand-computed N=8 schedule; events at or after cycle lim are not expected
  task automatic push8(input int t, input int lim);
    int a0t[12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int a1t[12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int twt[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      int s, rc;
      s  = i / 4;
      rc = t + 1 + 13 * s + (i % 4);
      if (rc < lim)     rq8.push_back('{rc, s, a0t[i], a1t[i], twt[i]});
      if (rc + 9 < lim) wq8.push_back('{rc + 9, s, a0t[i], a1t[i], 0});
    end
    if (t + 40 < lim) dq8.push_back(t + 40);
  endtask

  task automatic push256(input int t);
    int h, j, a0;
    for (int s = 0; s < 8; s++) begin
      h = 128 >> s;
      j = 0;
      for (int g = 0; g < 256 / (2 * h); g++) begin
        for (int k = 0; k < h; k++) begin
          a0 = g * 2 * h + k;
          rq256.push_back('{t + 1 + s * 137 + j, s, a0, a0 + h, k * (1 << s)});
          wq256.push_back('{t + 10 + s * 137 + j, s, a0, a0 + h, 0});
          j++;
        end
      end
    end
    dq256.push_back(t + 1097);
  endtask

  task automatic run8(input int lim_off, output int t);
    t = cyc;
    start8 = 1'b1;
    push8(t, t + lim_off);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  always @(negedge clk) begin : mon8
    ev_t e;
    if (rd8) begin
      if (rq8.size() == 0) chk("rd8_unexpected", cyc, -1);
      else begin
        e = rq8.pop_front();
        chk("rd8_cycle", cyc, e.cyc);
        chk("rd8_stage", stg8, e.stg);
        chk("rd8_addr0", ra0_8, e.a0);
        chk("rd8_addr1", ra1_8, e.a1);
        chk("rd8_tw", tw8, e.tw);
        chk("rd8_busy", busy8, 1);
      end
    end
    if (wr8) begin
      if (wq8.size() == 0) chk("wr8_unexpected", cyc, -1);
      else begin
        e = wq8.pop_front();
        chk("wr8_cycle", cyc, e.cyc);
        chk("wr8_addr0", wa0_8, e.a0);
        chk("wr8_addr1", wa1_8, e.a1);
      end
    end
    if (done8) begin
      if (dq8.size() == 0) chk("done8_unexpected", cyc, -1);
      else begin
        chk("done8_cycle", cyc, dq8.pop_front());
        chk("done8_busy", busy8, 0);
`ifdef NTT_CTRL_CYCCNT_EN
        chk("done8_cyc_cnt", cc8, 40);
`endif
      end
    end
  end

  always @(negedge clk) begin : mon256
    ev_t e;
    if (rd256) begin
      if (rq256.size() == 0) chk("rd256_unexpected", cyc, -1);
      else begin
        e = rq256.pop_front();
        chk("rd256_cycle", cyc, e.cyc);
        chk("rd256_stage", stg256, e.stg);
        chk("rd256_addr0", ra0_256, e.a0);
        chk("rd256_addr1", ra1_256, e.a1);
        chk("rd256_tw", tw256, e.tw);
      end
    end
    if (wr256) begin
      if (wq256.size() == 0) chk("wr256_unexpected", cyc, -1);
      else begin
        e = wq256.pop_front();
        chk("wr256_cycle", cyc, e.cyc);
        chk("wr256_addr0", wa0_256, e.a0);
        chk("wr256_addr1", wa1_256, e.a1);
      end
    end
    if (done256) begin
      if (dq256.size() == 0) chk("done256_unexpected", cyc, -1);
      else begin
        chk("done256_cycle", cyc, dq256.pop_front());
        chk("done256_busy", busy256, 0);
`ifdef NTT_CTRL_CYCCNT_EN
        chk("done256_cyc_cnt", cc256, 1097);
`endif
      end
    end
  end

  initial begin
    int ta, tb, tc, td, te;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_stage", stg8, 0);
    chk("rst_rd_en", rd8, 0);
    chk("rst_wr_en", wr8, 0);
    chk("rst_addrs", {ra0_8, ra1_8, tw8, wa0_8, wa1_8}, 0);
    chk("rst_busy256", busy256, 0);
`ifdef NTT_CTRL_CYCCNT_EN
    chk("rst_cyc_cnt", cc8, 0);
`endif

    // Full run with an extra start while busy, then a back-to-back restart
    run8(1000, ta);
    while (cyc != ta + 20) @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    while (cyc != ta + 41) @(negedge clk);
    run8(1000, tb);
    while (cyc != tb + 42) @(negedge clk);
    chk("restart_pending", rq8.size() + wq8.size() + dq8.size(), 0);

    // Abort with reset during stage 0 write-back
    run8(12, tc);
    while (cyc != tc + 11) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_wr_en", wr8, 0);
    chk("abort_rd_en", rd8, 0);
    chk("abort_busy", busy8, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_pending", rq8.size() + wq8.size() + dq8.size(), 0);
    chk("abort_idle_busy", busy8, 0);

    run8(1000, td);
    while (cyc != td + 42) @(negedge clk);
    chk("post_abort_pending", rq8.size() + wq8.size() + dq8.size(), 0);

    // Full-size transform
    te = cyc;
    start256 = 1'b1;
    push256(te);
    @(negedge clk);
    start256 = 1'b0;
    while (cyc != te + 1099) @(negedge clk);
    chk("n256_pending", rq256.size() + wq256.size() + dq256.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
